// File: rtl/downstream_cancel_store_if.sv
// Request/response bundle for the downstream cancelled-order store.
//   ack              request strobe (sampled by the store only while idle)
//   client_id        client index for a request, or for the idle query
//   amount           amount to add to the client's running total
//   cancelled_orders stored total of the addressed/updated client
//   update_memory    RAM write enable, high while the store is writing
//   memwr            write-complete flag, high for one cycle after the write
//   busy             high while a request is in flight
interface downstream_cancel_store_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  ack;
  logic [ADDR_WIDTH-1:0] client_id;
  logic [DATA_WIDTH-1:0] amount;
  logic [DATA_WIDTH-1:0] cancelled_orders;
  logic                  update_memory;
  logic                  memwr;
  logic                  busy;

  modport master (
    output ack, client_id, amount,
    input  cancelled_orders, update_memory, memwr, busy
  );

  modport slave (
    input  ack, client_id, amount,
    output cancelled_orders, update_memory, memwr, busy
  );
endinterface

// File: rtl/downstream_cancel_store.sv
// Per-client cancelled-order accumulator. An accepted ack reads the client's
// running total, adds the captured amount (modulo 2**DATA_WIDTH) and writes it
// back, reporting the new total on cancelled_orders. While idle, the store
// answers a query for client_id with one cycle of latency.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset; clears state, captures and memory
//   bus  slave side of downstream_cancel_store_if (see interface header)
module downstream_cancel_store #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  downstream_cancel_store_if.slave  bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] id_q;
  logic [DATA_WIDTH-1:0] amt_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] cancelled_q;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Carry out of the top bit is deliberately dropped.
  assign sum = old_q + amt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.ack) state_d = StRead;
      StRead:  state_d = StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      id_q        <= '0;
      amt_q       <= '0;
      old_q       <= '0;
      cancelled_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (bus.ack) begin
            id_q  <= bus.client_id;
            amt_q <= bus.amount;
          end else begin
            cancelled_q <= mem_q[bus.client_id];
          end
        end
        StRead:  old_q <= mem_q[id_q];
        StWrite: cancelled_q <= sum;
        default: ;
      endcase
    end
  end

  // Register-file RAM; the WRITE state is its only write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StWrite) begin
      mem_q[id_q] <= sum;
    end
  end

  assign bus.cancelled_orders = cancelled_q;
  assign bus.update_memory    = (state_q == StWrite);
  assign bus.memwr            = (state_q == StDone);
  assign bus.busy             = (state_q != StIdle);

endmodule

// File: tb/tb_downstream_cancel_store.sv
module tb_downstream_cancel_store;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  downstream_cancel_store_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  downstream_cancel_store #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Reference: one running total per client, updated per accepted request.
  logic [DW-1:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One full request; optionally hammers ack with other values while busy.
  task automatic do_req(input logic [AW-1:0] id, input logic [DW-1:0] amt, input bit noise,
                        input logic [AW-1:0] n_id, input logic [DW-1:0] n_amt);
    logic [DW-1:0] exp;
    exp = model[id] + amt;
    bus.ack = 1'b1; bus.client_id = id; bus.amount = amt;
    step();
    check_eq("read_busy", {31'b0, bus.busy}, 32'd1);
    check_eq("read_upd", {31'b0, bus.update_memory}, 32'd0);
    check_eq("read_memwr", {31'b0, bus.memwr}, 32'd0);
    bus.ack = noise; bus.client_id = n_id; bus.amount = n_amt;
    step();
    check_eq("write_upd", {31'b0, bus.update_memory}, 32'd1);
    check_eq("write_memwr", {31'b0, bus.memwr}, 32'd0);
    if (noise) begin bus.client_id = AW'($urandom); bus.amount = $urandom; end
    step();
    check_eq("done_memwr", {31'b0, bus.memwr}, 32'd1);
    check_eq("done_upd", {31'b0, bus.update_memory}, 32'd0);
    check_eq("done_total", bus.cancelled_orders, exp);
    model[id] = exp;
    step();
    check_eq("back_idle", {31'b0, bus.busy}, 32'd0);
    check_eq("idle_memwr", {31'b0, bus.memwr}, 32'd0);
    check_eq("idle_hold", bus.cancelled_orders, exp);
    bus.ack = 1'b0;
  endtask

  task automatic query(input logic [AW-1:0] id);
    bus.ack = 1'b0; bus.client_id = id; bus.amount = $urandom;
    step();
    check_eq($sformatf("query_%0d", id), bus.cancelled_orders, model[id]);
    check_eq("query_busy", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.ack = 1'b0; bus.client_id = '0; bus.amount = '0;
    clear_model();
    #2;
    check_eq("rst_co", bus.cancelled_orders, 32'd0);
    check_eq("rst_upd", {31'b0, bus.update_memory}, 32'd0);
    check_eq("rst_memwr", {31'b0, bus.memwr}, 32'd0);
    check_eq("rst_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) query(AW'(i));

    // Directed accumulation and cross-client isolation.
    do_req(5'd3, 32'd100, 1'b0, '0, '0);
    check_eq("id3_100", model[3], 32'd100);
    do_req(5'd3, 32'd50, 1'b0, '0, '0);
    check_eq("id3_150", bus.cancelled_orders, 32'd150);
    do_req(5'd7, 32'd20, 1'b0, '0, '0);
    query(5'd3);
    check_eq("id3_query", bus.cancelled_orders, 32'd150);
    query(5'd7);
    check_eq("id7_query", bus.cancelled_orders, 32'd20);

    // Wrap-around.
    do_req(5'd31, 32'hFFFF_FFFF, 1'b0, '0, '0);
    do_req(5'd31, 32'd2, 1'b0, '0, '0);
    check_eq("wrap", bus.cancelled_orders, 32'h0000_0001);

    // ack while busy is ignored.
    do_req(5'd4, 32'd11, 1'b1, 5'd5, 32'd9);
    query(5'd5);
    check_eq("ignored_5", bus.cancelled_orders, 32'd0);

    // Randomized requests (some back-to-back, some zero amounts) and queries.
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] id;
      logic [DW-1:0] amt;
      id  = AW'($urandom);
      amt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      do_req(id, amt, 1'($urandom), AW'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) query(AW'($urandom));
    end
    for (int i = 0; i < DEPTH; i++) query(AW'(i));

    // Reset in the middle of a WRITE.
    bus.ack = 1'b1; bus.client_id = 5'd3; bus.amount = 32'd77;
    step();
    bus.ack = 1'b0;
    step();
    check_eq("pre_rst_upd", {31'b0, bus.update_memory}, 32'd1);
    #2 rst = 1'b1;
    #1;
    clear_model();
    check_eq("mid_rst_co", bus.cancelled_orders, 32'd0);
    check_eq("mid_rst_upd", {31'b0, bus.update_memory}, 32'd0);
    check_eq("mid_rst_memwr", {31'b0, bus.memwr}, 32'd0);
    check_eq("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    query(5'd3);
    query(5'd7);
    do_req(5'd3, 32'd1, 1'b0, '0, '0);
    check_eq("post_rst_id3", bus.cancelled_orders, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
